uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (also used by the transmitter's
// state_bits) and bit-period arithmetic.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b11,
    ST_STOP  = 2'b10
  } uart_state_e;

  function automatic int unsigned clocks_per_bit(input int unsigned clk_rate,
                                                 input int unsigned baud_rate);
    return clk_rate / baud_rate;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle
// (high) level so reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
//
// state   | meaning
// IDLE    | waiting for a synchronized high-to-low edge
// START   | qualifying start bit at mid-bit (glitch reject)
// DATA    | sampling 8 data bits, one per bit period
// STOP    | sampling stop bit, then publish byte or flag framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy,
  output logic [1:0] state_bits
);

  localparam int unsigned CPB = clocks_per_bit(CLK_RATE, BAUD_RATE);
  localparam int          CW  = $clog2(CPB);
  localparam logic [CW-1:0] MID      = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_DEC = CW'(CPB / 2);
`else
  localparam logic [CW-1:0] START_DEC = MID;
`endif

  logic rx_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          armed_q, armed_d;
  logic [1:0]    flush_q, flush_d;
  logic          sample;

`ifdef UART_RX_MAJORITY_EN
  // Holds rx_s from the two cycles before the decision point.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[0], rx_s};
    sample = majority3(hist_q[1], hist_q[0], rx_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  always_comb begin
    sample = rx_s;
  end
`endif

  // armed_q means "in IDLE, synchronizer flushed, line seen high last cycle",
  // so a low line left over from reset or a bad stop bit never starts a frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    armed_d   = 1'b0;
    flush_d   = {flush_q[0], 1'b1};

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        armed_d = flush_q[1] & rx_s;
        if (armed_q && !rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == START_DEC) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sample ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {sample, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
      flush_q   <= flush_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != ST_IDLE);
  assign state_bits  = state_q;

endmodule
